// File: rtl/imem_line_responder_pkg.sv
// Shared types and constants for the imem line responder.
// The line buffer's tag/HIT path is built only with IMEM_LINE_BUF_EN defined.
package imem_resp_pkg;

    localparam int unsigned LINE_BEATS_DEF = 4;
    localparam int unsigned BEAT_W_DEF     = 64;
    localparam int unsigned LINE_BYTES     = LINE_BEATS_DEF * BEAT_W_DEF / 8;
    localparam int unsigned OFFSET_W       = $clog2(LINE_BYTES);

    typedef logic [LINE_BEATS_DEF-1:0][BEAT_W_DEF-1:0] line_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HIT  = 3'd1,
        ST_REQ  = 3'd2,
        ST_FILL = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Byte-offset width of a line for a given beat count and beat width.
    function automatic int unsigned off_w(input int unsigned beats, input int unsigned beat_w);
        return $clog2(beats * beat_w / 8);
    endfunction

endpackage

// File: rtl/imem_line_responder_if.sv
// Fetch-side imem request bus plus backing-memory burst port.
// slave = the responder, master = fetch unit / bmem side.
interface imem_line_responder_if #(
    parameter int unsigned BEAT_W = 64
) ();
    logic [31:0]       imem_addr;
    logic [3:0]        imem_rmask;
    logic              imem_rqst;
    logic              imem_flush;
    logic              imem_ready;
    logic              imem_resp;
    logic [31:0]       imem_rdata;
    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_ready;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport slave (
        input  imem_addr, imem_rmask, imem_rqst, imem_flush,
        output imem_ready, imem_resp, imem_rdata,
        output bmem_addr, bmem_read,
        input  bmem_ready, bmem_rdata, bmem_rvalid
    );

    modport master (
        output imem_addr, imem_rmask, imem_rqst, imem_flush,
        input  imem_ready, imem_resp, imem_rdata,
        input  bmem_addr, bmem_read,
        output bmem_ready, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/imem_line_buf.sv
// Single cache-line store: beat write port, 32-bit word read mux, and
// (with IMEM_LINE_BUF_EN) the tag/valid pair used for hit detection.
module imem_line_buf
    import imem_resp_pkg::*;
#(
    parameter int unsigned LINE_BEATS = 4,
    parameter int unsigned BEAT_W     = 64
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               wr_en_i,
    input  logic [$clog2(LINE_BEATS)-1:0]                      wr_idx_i,
    input  logic [BEAT_W-1:0]                                  wr_data_i,
`ifdef IMEM_LINE_BUF_EN
    input  logic                                               install_i,
    input  logic [31:off_w(LINE_BEATS, BEAT_W)]                install_tag_i,
    input  logic [31:off_w(LINE_BEATS, BEAT_W)]                lookup_tag_i,
`endif
    input  logic [off_w(LINE_BEATS, BEAT_W)-1:2]               rd_word_i,
    output logic                                               hit_o,
    output logic [31:0]                                        rd_data_o
);

    localparam int unsigned OFF_W = off_w(LINE_BEATS, BEAT_W);

    logic [LINE_BEATS-1:0][BEAT_W-1:0] line_q;
    logic [LINE_BEATS*BEAT_W-1:0]      line_flat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else if (wr_en_i) begin
            line_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign line_flat = line_q;
    assign rd_data_o = line_flat[32*rd_word_i +: 32];

`ifdef IMEM_LINE_BUF_EN
    logic             valid_q;
    logic [31:OFF_W]  tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else if (install_i) begin
            valid_q <= 1'b1;
            tag_q   <= install_tag_i;
        end
    end

    assign hit_o = valid_q && (tag_q == lookup_tag_i);
`else
    // Without the buffer feature the line only carries the pending response.
    assign hit_o = 1'b0;
`endif

endmodule

// File: rtl/imem_line_responder.sv
// Instruction-memory responder: serves word reads from one buffered line,
// refilling it with a bmem burst on a miss. Tag reuse needs IMEM_LINE_BUF_EN.
module imem_line_responder
    import imem_resp_pkg::*;
#(
    parameter int unsigned LINE_BEATS = 4,
    parameter int unsigned BEAT_W     = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_line_responder_if.slave  bus
);

    localparam int unsigned OFF_W = off_w(LINE_BEATS, BEAT_W);
    localparam int unsigned CNT_W = $clog2(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    state_t             state_q, state_d;
    logic [31:2]        addr_q, addr_d;
    logic [31:0]        bmem_addr_q, bmem_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drop_q, drop_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               accept;
    logic               hit;
    logic               beat_we;
    logic               resp;
    logic [31:0]        word;
`ifdef IMEM_LINE_BUF_EN
    logic               install;
`endif

    imem_line_buf #(
        .LINE_BEATS (LINE_BEATS),
        .BEAT_W     (BEAT_W)
    ) u_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en_i       (beat_we),
        .wr_idx_i      (cnt_q),
        .wr_data_i     (bus.bmem_rdata),
`ifdef IMEM_LINE_BUF_EN
        .install_i     (install),
        .install_tag_i (addr_q[31:OFF_W]),
        .lookup_tag_i  (bus.imem_addr[31:OFF_W]),
`endif
        .rd_word_i     (addr_q[OFF_W-1:2]),
        .hit_o         (hit),
        .rd_data_o     (word)
    );

    assign accept = bus.imem_rqst && (|bus.imem_rmask) && !bus.imem_flush;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bmem_addr_d = bmem_addr_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        rdata_d     = rdata_q;
        beat_we     = 1'b0;
        resp        = 1'b0;
`ifdef IMEM_LINE_BUF_EN
        install     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d = bus.imem_addr[31:2];
                    if (hit) begin
                        state_d = ST_HIT;
                    end else begin
                        bmem_addr_d = {bus.imem_addr[31:OFF_W], {OFF_W{1'b0}}};
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_HIT: begin
                // A flush here both suppresses and consumes the drop, so the flag never leaks.
                resp    = !bus.imem_flush;
                drop_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_REQ: begin
                if (bus.imem_flush) drop_d = 1'b1;
                if (bus.bmem_ready) begin
                    cnt_d   = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (bus.imem_flush) drop_d = 1'b1;
                if (bus.bmem_rvalid) begin
                    beat_we = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
`ifdef IMEM_LINE_BUF_EN
                        install = 1'b1;
`endif
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RESP: begin
                resp    = !drop_q && !bus.imem_flush;
                drop_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (resp) rdata_d = word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            bmem_addr_q <= '0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bmem_addr_q <= bmem_addr_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.imem_ready = (state_q == ST_IDLE);
    assign bus.imem_resp  = resp;
    assign bus.imem_rdata = resp ? word : rdata_q;
    assign bus.bmem_read  = (state_q == ST_REQ);
    assign bus.bmem_addr  = bmem_addr_q;

endmodule

// File: tb/tb_imem_line_responder.sv
// Self-checking bench: the bench plays fetch unit and bmem, and predicts
// every response from an address-indexed word model plus a one-line tag model.
module tb_imem_line_responder;

    localparam int unsigned LB = 4;
    localparam int unsigned BW = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic        m_valid;
    logic [26:0] m_tag;
    logic [31:0] last_rd;

    imem_line_responder_if #(.BEAT_W(BW)) bus ();

    imem_line_responder #(
        .LINE_BEATS (LB),
        .BEAT_W     (BW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Backing memory contents, one 32-bit word per word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (wa == 32'h1ECE_B000) return 32'h0000_0013;
        if (wa == 32'h1ECE_B004) return 32'h1111_1111;
        return (wa * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    function automatic logic model_hit(input logic [31:0] a);
`ifdef IMEM_LINE_BUF_EN
        return m_valid && (m_tag == a[31:5]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_check(input string tag);
        #1;
        chk({tag, ".ready"}, bus.imem_ready, 1'b1);
        chk({tag, ".resp"},  bus.imem_resp,  1'b0);
        chk({tag, ".bread"}, bus.bmem_read,  1'b0);
        chk({tag, ".rdata"}, bus.imem_rdata, last_rd);
    endtask

    // fl: 0 none, 1 flush in REQ, 2 flush on beat 2, 3 flush in RESP, 4 flush in HIT.
    // bp: cycles of bmem_ready=0 before acceptance, negative = random.
    task automatic do_req(input logic [31:0] a, input int fl, input int bp);
        logic        exp_hit;
        logic        exp_resp;
        logic [31:0] line;
        logic [31:0] exp_w;
        int          nbp;
        int          gaps;
        line    = {a[31:5], 5'b0};
        exp_hit = model_hit(a);
        exp_w   = mem_word(a);
        idle_check("pre");
        bus.imem_addr  = a;
        bus.imem_rmask = 4'($urandom_range(1, 15));
        bus.imem_rqst  = 1'b1;
        step();
        bus.imem_rqst = 1'b0;
        bus.imem_addr = $urandom;
        if (exp_hit) begin
            exp_resp = (fl != 4);
            if (fl == 4) bus.imem_flush = 1'b1;
            #1;
            chk("hit.resp",  bus.imem_resp, exp_resp);
            chk("hit.bread", bus.bmem_read, 1'b0);
            chk("hit.rdata", bus.imem_rdata, exp_resp ? exp_w : last_rd);
            step();
            bus.imem_flush = 1'b0;
        end else begin
            exp_resp = !(fl inside {1, 2, 3});
            nbp = (bp < 0) ? int'($urandom_range(0, 3)) : bp;
            for (int k = 0; k <= nbp; k++) begin
                bus.bmem_ready = (k == nbp);
                if (fl == 1 && k == 0) bus.imem_flush = 1'b1;
                #1;
                chk("req.bread", bus.bmem_read, 1'b1);
                chk("req.baddr", bus.bmem_addr, line);
                chk("req.resp",  bus.imem_resp, 1'b0);
                step();
                bus.imem_flush = 1'b0;
            end
            bus.bmem_ready = 1'b0;
            for (int b = 0; b < int'(LB); b++) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    bus.bmem_rvalid = 1'b0;
                    bus.bmem_rdata  = {$urandom, $urandom};
                    #1;
                    chk("fill.resp", bus.imem_resp, 1'b0);
                    step();
                end
                bus.bmem_rvalid = 1'b1;
                bus.bmem_rdata  = {mem_word(line + 32'(8*b + 4)), mem_word(line + 32'(8*b))};
                if (fl == 2 && b == 2) bus.imem_flush = 1'b1;
                #1;
                chk("fill.resp",  bus.imem_resp, 1'b0);
                chk("fill.bread", bus.bmem_read, 1'b0);
                step();
                bus.bmem_rvalid = 1'b0;
                bus.bmem_rdata  = {$urandom, $urandom};
                bus.imem_flush  = 1'b0;
            end
            if (fl == 3) bus.imem_flush = 1'b1;
            #1;
            chk("miss.resp",  bus.imem_resp, exp_resp);
            chk("miss.rdata", bus.imem_rdata, exp_resp ? exp_w : last_rd);
            step();
            bus.imem_flush = 1'b0;
            m_valid = 1'b1;
            m_tag   = a[31:5];
        end
        if (exp_resp) last_rd = exp_w;
    endtask

    initial begin
        logic [31:0] lines [4];
        logic [31:0] ra;
        int          r;
        lines[0] = 32'h1ECE_B000;
        lines[1] = 32'h1ECE_B020;
        lines[2] = 32'h0040_0000;
        lines[3] = 32'hFFFF_FFE0;

        m_valid = 1'b0;
        m_tag   = '0;
        last_rd = '0;
        bus.imem_addr   = '0;
        bus.imem_rmask  = '0;
        bus.imem_rqst   = 1'b0;
        bus.imem_flush  = 1'b0;
        bus.bmem_ready  = 1'b0;
        bus.bmem_rdata  = '0;
        bus.bmem_rvalid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst.ready", bus.imem_ready, 1'b1);
        chk("rst.resp",  bus.imem_resp,  1'b0);
        chk("rst.rdata", bus.imem_rdata, 32'h0);
        chk("rst.bread", bus.bmem_read,  1'b0);
        chk("rst.baddr", bus.bmem_addr,  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Cold miss with three cycles of bmem backpressure, then the neighbouring word.
        do_req(32'h1ECE_B000, 0, 3);
        chk("cold.rdata", last_rd, 32'h0000_0013);
        do_req(32'h1ECE_B004, 0, 0);

        // Mid-cycle reset during REQ; stray beats afterwards are ignored.
        idle_check("pre_rst");
        bus.imem_addr  = 32'h1ECE_B010;
        bus.imem_rmask = 4'hF;
        bus.imem_rqst  = 1'b1;
        step();
        bus.imem_rqst = 1'b0;
        #1;
        chk("rst2.bread_before", bus.bmem_read, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2.ready", bus.imem_ready, 1'b1);
        chk("rst2.bread", bus.bmem_read,  1'b0);
        chk("rst2.baddr", bus.bmem_addr,  32'h0);
        chk("rst2.rdata", bus.imem_rdata, 32'h0);
        m_valid = 1'b0;
        last_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = {$urandom, $urandom};
            idle_check("stray");
            step();
        end
        bus.bmem_rvalid = 1'b0;

        // Flushed fill still installs the line; the next word in it then hits.
        do_req(32'h1ECE_B00C, 2, -1);
        do_req(32'h1ECE_B008, 0, -1);

        // Flush coinciding with a request, and a zero-mask request: both ignored.
        bus.imem_addr  = 32'h0040_0004;
        bus.imem_rmask = 4'hF;
        bus.imem_rqst  = 1'b1;
        bus.imem_flush = 1'b1;
        step();
        bus.imem_rqst  = 1'b0;
        bus.imem_flush = 1'b0;
        idle_check("idle_flush");
        bus.imem_rmask = 4'h0;
        bus.imem_rqst  = 1'b1;
        step();
        bus.imem_rqst = 1'b0;
        idle_check("zero_mask");

        // Flush in HIT (or in a plain miss without the buffer), flush in REQ and RESP.
        do_req(32'h1ECE_B01C, 4, -1);
        do_req(32'h0040_0008, 1, -1);
        do_req(32'h0040_000C, 3, -1);
        do_req(32'h0040_0010, 0, -1);

        for (int i = 0; i < 40; i++) begin
            ra = lines[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
            r  = $urandom_range(0, 9);
            do_req(ra, (r < 6) ? 0 : r - 5, -1);
        end
        idle_check("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
